// File: rtl/penny_pin_test_sequencer.sv
// Penny board-wiring test sequencer.
// Drives all test pins from one registered pattern bus and steps through
// ALL0 -> ALL1 -> WALK1 -> WALK0 -> DIVCLK, on a dwell timer or manual advance.
// Handshake: start/advance are single-cycle pulses sampled on the rising clock
// edge; abort is level-sensitive and overrides every other request that cycle.
// led[2:0] mirrors the FSM state code so checkers can observe the state.
module penny_pin_test_sequencer #(
   parameter int NPINS        = 49,
   parameter int DWELL_CYCLES = 125_000_000,
   parameter int DIV_TAP      = 6
) (
   input  logic             _125MHZ,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic             loop,
   input  logic             manual,
   input  logic             advance,
   output logic [NPINS-1:0] pin_bus,
   output logic [7:0]       led,
   output logic             busy,
   output logic             done,
   output logic [5:0]       step,
   output logic [7:0]       pass_count
);

   localparam int DIVW = DIV_TAP + 22;
   localparam int DWW  = $clog2(DWELL_CYCLES);
   localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_CYCLES - 1);
   localparam logic [5:0]     STEP_LAST  = 6'(NPINS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ALL0   = 3'd1,
      ALL1   = 3'd2,
      WALK1  = 3'd3,
      WALK0  = 3'd4,
      DIVCLK = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [5:0]       step_nx;
   logic [DWW-1:0]   dwell;
   logic [DWW-1:0]   dwell_nx;
   logic [7:0]       pass_nx;
   logic [DIVW-1:0]  divcnt;
   logic [DIVW-1:0]  divcnt_nx;
   logic [NPINS-1:0] walk_bit;
   logic [NPINS-1:0] pattern_nx;
   logic             step_end;
   logic             heartbeat;

   assign divcnt_nx = divcnt + 1'b1;
   assign heartbeat = divcnt[DIVW-1];
   assign led       = {heartbeat, ~heartbeat, 3'b000, state};
   // In manual mode only advance ends a step; in auto mode only the dwell timer does.
   assign step_end  = manual ? advance : (dwell == DWELL_LAST);
   assign walk_bit  = NPINS'(1) << step_nx;

   // Next-state, step index, dwell timer and pass counter.
   always_comb begin
      state_nx = state;
      step_nx  = step;
      dwell_nx = dwell;
      pass_nx  = pass_count;
      if (abort) begin
         state_nx = IDLE;
         step_nx  = '0;
         dwell_nx = '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               step_nx  = '0;
               dwell_nx = '0;
               if (start) state_nx = ALL0;
            end
            default: begin
               if (step_end) begin
                  dwell_nx = '0;
                  case (state)
                     ALL0: state_nx = ALL1;
                     ALL1: begin
                        state_nx = WALK1;
                        step_nx  = '0;
                     end
                     WALK1: begin
                        if (step == STEP_LAST) begin
                           state_nx = WALK0;
                           step_nx  = '0;
                        end else begin
                           step_nx = step + 6'd1;
                        end
                     end
                     WALK0: begin
                        if (step == STEP_LAST) begin
                           state_nx = DIVCLK;
                           step_nx  = '0;
                        end else begin
                           step_nx = step + 6'd1;
                        end
                     end
                     DIVCLK: begin
                        pass_nx  = pass_count + 8'd1;
                        state_nx = loop ? ALL0 : DONE;
                     end
                     default: state_nx = IDLE;
                  endcase
               end else if (!manual) begin
                  dwell_nx = dwell + 1'b1;
               end
            end
         endcase
      end
   end

   // Pattern for the upcoming state, so the registered bus lines up with the state register.
   always_comb begin
      pattern_nx = '0;
      case (state_nx)
         ALL1:    pattern_nx = '1;
         WALK1:   pattern_nx = walk_bit;
         WALK0:   pattern_nx = ~walk_bit;
         DIVCLK: begin
            for (int i = 0; i < NPINS; i++) begin
               pattern_nx[i] = divcnt_nx[DIV_TAP + (i % 22)];
            end
         end
         default: pattern_nx = '0;
      endcase
   end

   // State register and registered outputs.
   always_ff @(posedge _125MHZ or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         step       <= '0;
         dwell      <= '0;
         divcnt     <= '0;
         pass_count <= '0;
         pin_bus    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         step       <= step_nx;
         dwell      <= dwell_nx;
         divcnt     <= divcnt_nx;
         pass_count <= pass_nx;
         pin_bus    <= pattern_nx;
         busy       <= (state_nx != IDLE) && (state_nx != DONE);
         done       <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_penny_pin_test_sequencer.sv
// Directed bench for penny_pin_test_sequencer with a 4-cycle dwell.
module tb_penny_pin_test_sequencer;

   localparam int NPINS   = 49;
   localparam int DWELL   = 4;
   localparam int DIV_TAP = 6;
   localparam int SEQ_LEN = (2 * NPINS + 3) * DWELL;  // 404

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             loop = 1'b0;
   logic             manual = 1'b0;
   logic             advance = 1'b0;
   logic [NPINS-1:0] pin_bus;
   logic [7:0]       led;
   logic             busy;
   logic             done;
   logic [5:0]       step;
   logic [7:0]       pass_count;

   int errors = 0;
   int checks = 0;

   penny_pin_test_sequencer #(
      .NPINS(NPINS),
      .DWELL_CYCLES(DWELL),
      .DIV_TAP(DIV_TAP)
   ) dut (
      ._125MHZ(clk),
      .reset_n(reset_n),
      .start(start),
      .abort(abort),
      .loop(loop),
      .manual(manual),
      .advance(advance),
      .pin_bus(pin_bus),
      .led(led),
      .busy(busy),
      .done(done),
      .step(step),
      .pass_count(pass_count)
   );

   always #5 clk = ~clk;

   // Advance n rising edges; return 1 ns after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic pulse_advance();
      advance = 1'b1;
      tick(1);
      advance = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   // Expected state code k cycles after ALL0 is entered in auto mode.
   function automatic logic [2:0] exp_state(input int k);
      int s;
      s = k / DWELL;
      if (s == 0) return 3'd1;
      if (s == 1) return 3'd2;
      if (s <= 50) return 3'd3;
      if (s <= 99) return 3'd4;
      if (s == 100) return 3'd5;
      return 3'd6;
   endfunction

   function automatic logic [5:0] exp_step(input int k);
      int s;
      s = k / DWELL;
      if (s >= 2 && s <= 50) return 6'(s - 2);
      if (s >= 51 && s <= 99) return 6'(s - 51);
      return 6'd0;
   endfunction

   function automatic logic [NPINS-1:0] exp_pins(input logic [2:0] st, input logic [5:0] sp);
      logic [NPINS-1:0] one;
      one = 1;
      case (st)
         3'd2:    return '1;
         3'd3:    return one << sp;
         3'd4:    return ~(one << sp);
         default: return '0;
      endcase
   endfunction

   task automatic test_reset();
      #2;
      reset_n = 1'b0;
      tick(3);
      checks++; if (led !== 8'h40) begin errors++; $display("FAIL reset_led got=%h exp=40", led); end
      checks++; if (pin_bus !== '0) begin errors++; $display("FAIL reset_pins got=%h exp=0", pin_bus); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {busy, done}); end
      checks++; if (pass_count !== 8'd0) begin errors++; $display("FAIL reset_pass got=%0d exp=0", pass_count); end
      checks++; if (step !== 6'd0) begin errors++; $display("FAIL reset_step got=%0d exp=0", step); end
      reset_n = 1'b1;
      tick(2);
      checks++; if (led !== 8'h40) begin errors++; $display("FAIL idle_led got=%h exp=40", led); end
   endtask

   task automatic test_async_reset();
      pulse_start();
      tick(20);  // WALK1, step 3
      checks++; if (led[2:0] !== 3'd3 || step !== 6'd3) begin errors++; $display("FAIL pre_reset_walk st=%0d step=%0d exp=3/3", led[2:0], step); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (pin_bus !== '0) begin errors++; $display("FAIL async_pins got=%h exp=0", pin_bus); end
      checks++; if (led !== 8'h40) begin errors++; $display("FAIL async_led got=%h exp=40", led); end
      checks++; if (step !== 6'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_step_busy step=%0d busy=%b exp=0/0", step, busy); end
      tick(2);
      reset_n = 1'b1;
      tick(10);
      checks++; if (led[2:0] !== 3'd0 || busy !== 1'b0 || pin_bus !== '0) begin errors++; $display("FAIL stay_idle st=%0d busy=%b pins=%h", led[2:0], busy, pin_bus); end
   endtask

   task automatic test_auto_sequence();
      logic [2:0] es;
      logic [5:0] ep;
      pulse_start();
      for (int k = 0; k < SEQ_LEN; k++) begin
         es = exp_state(k);
         ep = exp_step(k);
         checks++; if (led[2:0] !== es) begin errors++; $display("FAIL seq_state k=%0d got=%0d exp=%0d", k, led[2:0], es); end
         checks++; if (step !== ep) begin errors++; $display("FAIL seq_step k=%0d got=%0d exp=%0d", k, step, ep); end
         checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL seq_flags k=%0d busy=%b done=%b exp=1/0", k, busy, done); end
         if (es != 3'd5) begin
            checks++; if (pin_bus !== exp_pins(es, ep)) begin errors++; $display("FAIL seq_pins k=%0d got=%h exp=%h", k, pin_bus, exp_pins(es, ep)); end
         end
         tick(1);
      end
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL seq_done done=%b busy=%b exp=1/0", done, busy); end
      checks++; if (led[2:0] !== 3'd6) begin errors++; $display("FAIL seq_done_state got=%0d exp=6", led[2:0]); end
      checks++; if (pass_count !== 8'd1) begin errors++; $display("FAIL seq_pass got=%0d exp=1", pass_count); end
      checks++; if (pin_bus !== '0) begin errors++; $display("FAIL seq_done_pins got=%h exp=0", pin_bus); end
   endtask

   task automatic test_manual();
      // Pausing mid-step keeps the dwell count.
      pulse_start();   // k=0, dwell 0
      tick(2);         // k=2, dwell 2
      manual = 1'b1;
      tick(5);         // k=7, dwell held at 2
      checks++; if (led[2:0] !== 3'd1) begin errors++; $display("FAIL pause_state got=%0d exp=1", led[2:0]); end
      manual = 1'b0;
      tick(1);         // k=8, dwell 3
      checks++; if (led[2:0] !== 3'd1) begin errors++; $display("FAIL resume_hold got=%0d exp=1", led[2:0]); end
      tick(1);         // k=9, ALL1 entered
      checks++; if (led[2:0] !== 3'd2) begin errors++; $display("FAIL resume_end got=%0d exp=2", led[2:0]); end
      // advance is ignored in auto mode.
      pulse_advance(); // k=10
      tick(2);         // k=12
      checks++; if (led[2:0] !== 3'd2) begin errors++; $display("FAIL auto_adv_ignored got=%0d exp=2", led[2:0]); end
      tick(1);         // k=13
      checks++; if (led[2:0] !== 3'd3) begin errors++; $display("FAIL auto_all1_len got=%0d exp=3", led[2:0]); end
      pulse_abort();
      // Manual stepping.
      manual = 1'b1;
      pulse_start();
      tick(10);
      checks++; if (led[2:0] !== 3'd1) begin errors++; $display("FAIL manual_no_progress got=%0d exp=1", led[2:0]); end
      pulse_advance();
      tick(6);
      checks++; if (led[2:0] !== 3'd2 || pin_bus !== '1) begin errors++; $display("FAIL manual_all1 st=%0d pins=%h", led[2:0], pin_bus); end
      pulse_advance();
      pulse_advance();
      checks++; if (led[2:0] !== 3'd3 || step !== 6'd1) begin errors++; $display("FAIL manual_walk st=%0d step=%0d exp=3/1", led[2:0], step); end
      checks++; if (pin_bus !== 49'h2) begin errors++; $display("FAIL manual_pins got=%h exp=2", pin_bus); end
      tick(8);
      checks++; if (step !== 6'd1 || pass_count !== 8'd1) begin errors++; $display("FAIL manual_hold step=%0d pass=%0d exp=1/1", step, pass_count); end
      pulse_abort();
      manual = 1'b0;
   endtask

   task automatic test_loop();
      do_reset();
      loop = 1'b1;
      pulse_start();
      for (int k = 0; k <= 2 * SEQ_LEN; k++) begin
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy k=%0d got=%b exp=1", k, busy); end
         if (k == SEQ_LEN) begin
            checks++; if (led[2:0] !== 3'd1 || pass_count !== 8'd1) begin errors++; $display("FAIL loop_first st=%0d pass=%0d exp=1/1", led[2:0], pass_count); end
         end
         if (k < 2 * SEQ_LEN) tick(1);
      end
      checks++; if (led[2:0] !== 3'd1) begin errors++; $display("FAIL loop_state got=%0d exp=1", led[2:0]); end
      checks++; if (pass_count !== 8'd2) begin errors++; $display("FAIL loop_pass got=%0d exp=2", pass_count); end
      loop = 1'b0;
      pulse_abort();
   endtask

   task automatic test_abort_start();
      pulse_start();
      tick(245);  // WALK0 step 10
      checks++; if (led[2:0] !== 3'd4 || step !== 6'd10) begin errors++; $display("FAIL pre_abort st=%0d step=%0d exp=4/10", led[2:0], step); end
      checks++; if (pin_bus !== ~(49'h1 << 10)) begin errors++; $display("FAIL pre_abort_pins got=%h", pin_bus); end
      abort = 1'b1;
      start = 1'b1;
      tick(1);
      abort = 1'b0;
      start = 1'b0;
      checks++; if (led[2:0] !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_state st=%0d busy=%b exp=0/0", led[2:0], busy); end
      checks++; if (pin_bus !== '0 || step !== 6'd0) begin errors++; $display("FAIL abort_pins pins=%h step=%0d", pin_bus, step); end
      checks++; if (pass_count !== 8'd2) begin errors++; $display("FAIL abort_pass got=%0d exp=2", pass_count); end
      tick(3);
      checks++; if (led[2:0] !== 3'd0) begin errors++; $display("FAIL abort_stays got=%0d exp=0", led[2:0]); end
   endtask

   task automatic test_divclk();
      int toggles[$];
      logic prev;
      pulse_start();
      tick(400);
      manual = 1'b1;  // freeze in DIVCLK
      checks++; if (led[2:0] !== 3'd5) begin errors++; $display("FAIL div_enter got=%0d exp=5", led[2:0]); end
      prev = pin_bus[0];
      for (int i = 0; i < 200; i++) begin
         start = (i == 100);
         tick(1);
         if (pin_bus[0] !== prev) toggles.push_back(i);
         prev = pin_bus[0];
         checks++; if (pin_bus[22] !== pin_bus[0] || pin_bus[48] !== pin_bus[4]) begin errors++; $display("FAIL div_alias i=%0d pins=%h", i, pin_bus); end
      end
      start = 1'b0;
      checks++; if (toggles.size() < 3) begin errors++; $display("FAIL div_toggle_count got=%0d exp>=3", toggles.size()); end
      for (int j = 1; j < toggles.size(); j++) begin
         checks++; if (toggles[j] - toggles[j-1] != 64) begin errors++; $display("FAIL div_period got=%0d exp=64", toggles[j] - toggles[j-1]); end
      end
      checks++; if (led[2:0] !== 3'd5 || pass_count !== 8'd2) begin errors++; $display("FAIL busy_start st=%0d pass=%0d exp=5/2", led[2:0], pass_count); end
      pulse_advance();
      checks++; if (done !== 1'b1 || led[2:0] !== 3'd6) begin errors++; $display("FAIL div_done done=%b st=%0d", done, led[2:0]); end
      checks++; if (pass_count !== 8'd3 || pin_bus !== '0) begin errors++; $display("FAIL div_pass pass=%0d pins=%h", pass_count, pin_bus); end
      manual = 1'b0;
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_auto_sequence();
      test_manual();
      test_loop();
      test_abort_start();
      test_divclk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
